// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus: IRAM read port plus the decoded-instruction handshake.
interface instr_fetch_unit_if;
    logic [1:0]  mem_ctrl;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_opcode;
    logic [4:0]  instr_opa;
    logic [4:0]  instr_opb;
    logic [15:0] instr_imm;
    logic        jmp_cond;

    // Fetch unit side
    modport master (
        output mem_ctrl, mem_addr, instr_valid, instr_opcode, instr_opa, instr_opb, instr_imm,
        input  mem_data, instr_ready, jmp_cond
    );

    // IRAM / execute side
    modport slave (
        input  mem_ctrl, mem_addr, instr_valid, instr_opcode, instr_opa, instr_opb, instr_imm,
        output mem_data, instr_ready, jmp_cond
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads one- or two-word instructions from IRAM,
// presents them on a valid/ready handshake and follows LOAD/JMPZ/END.
// Optional macro IFU_BOUNDS_CHECK_EN: fetches above word 63 fault and halt.
module instr_fetch_unit (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    instr_fetch_unit_if.master  bus,
    output logic [15:0]         pc,
    output logic                halted,
    output logic                fault
);
    localparam int unsigned WORD_W = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 2;

    localparam logic [OP_W-1:0]   OP_END   = 4'd1;
    localparam logic [OP_W-1:0]   OP_LOAD  = 4'd4;
    localparam logic [OP_W-1:0]   OP_JMPZ  = 4'd15;
    localparam logic [CTRL_W-1:0] MEM_READ = 2'd1;
    localparam logic [CTRL_W-1:0] MEM_IDLE = 2'd0;
`ifdef IFU_BOUNDS_CHECK_EN
    localparam logic [WORD_W-1:0] ADDR_MAX = 16'd63;
`endif

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, FETCH_IMM, LATCH_IMM, ISSUE, HALT} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   pc_q, pc_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [WORD_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [REG_W-1:0]    opa_q, opa_d;
    logic [REG_W-1:0]    opb_q, opb_d;
    logic [WORD_W-1:0]   imm_q, imm_d;
    logic                halted_q, halted_d;
    logic                fault_q, fault_d;
    logic                go_fetch, go_imm;
    logic [WORD_W-1:0]   fetch_addr;
    logic [WORD_W-1:0]   next_pc;

    // State and registered outputs; reset clears everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ctrl_q   <= MEM_IDLE;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            imm_q    <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ctrl_q   <= ctrl_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            imm_q    <= imm_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state and next-output logic; a read is issued only on entry to a fetch state
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ctrl_d     = MEM_IDLE;
        addr_d     = addr_q;
        valid_d    = valid_q;
        op_d       = op_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        imm_d      = imm_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        go_fetch   = 1'b0;
        go_imm     = 1'b0;
        fetch_addr = pc_q;
        next_pc    = pc_q + WORD_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d       = '0;
                    go_fetch   = 1'b1;
                    fetch_addr = '0;
                end
            end
            FETCH:     state_d = LATCH;
            LATCH: begin
                op_d  = bus.mem_data[15:12];
                opa_d = bus.mem_data[11:7];
                opb_d = bus.mem_data[6:2];
                if (bus.mem_data[15:12] == OP_LOAD || bus.mem_data[15:12] == OP_JMPZ) begin
                    go_fetch   = 1'b1;
                    go_imm     = 1'b1;
                    fetch_addr = pc_q + WORD_W'(1);
                end else begin
                    imm_d   = '0;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            FETCH_IMM: state_d = LATCH_IMM;
            LATCH_IMM: begin
                imm_d   = bus.mem_data;
                valid_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    if (op_q == OP_END) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        if (op_q == OP_JMPZ && bus.jmp_cond) begin
                            next_pc = imm_q;
                        end else if (op_q == OP_LOAD || op_q == OP_JMPZ) begin
                            next_pc = pc_q + WORD_W'(2);
                        end
                        pc_d       = next_pc;
                        go_fetch   = 1'b1;
                        fetch_addr = next_pc;
                    end
                end
            end
            HALT:      state_d = HALT;
            default:   state_d = IDLE;
        endcase

        if (go_fetch) begin
`ifdef IFU_BOUNDS_CHECK_EN
            if (fetch_addr > ADDR_MAX) begin
                fault_d  = 1'b1;
                halted_d = 1'b1;
                state_d  = HALT;
            end else
`endif
            begin
                ctrl_d  = MEM_READ;
                addr_d  = fetch_addr;
                state_d = go_imm ? FETCH_IMM : FETCH;
            end
        end
    end

    assign pc               = pc_q;
    assign halted           = halted_q;
    assign fault            = fault_q;
    assign bus.mem_ctrl     = ctrl_q;
    assign bus.mem_addr     = addr_q;
    assign bus.instr_valid  = valid_q;
    assign bus.instr_opcode = op_q;
    assign bus.instr_opa    = opa_q;
    assign bus.instr_opb    = opb_q;
    assign bus.instr_imm    = imm_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// programs checked against an instruction-level model of the fetch rules.
module tb_instr_fetch_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pc;
    logic        halted;
    logic        fault;
    int          checks = 0;
    int          fails  = 0;
    int unsigned reads  = 0;
    logic [15:0] iram [65536];

    instr_fetch_unit_if bus();

    instr_fetch_unit dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .bus    (bus),
        .pc     (pc),
        .halted (halted),
        .fault  (fault)
    );

    always #5 clock = ~clock;

    // IRAM model: data appears the cycle after a read request
    always @(posedge clock) begin
        if (bus.mem_ctrl == 2'd1) begin
            bus.mem_data <= iram[bus.mem_addr];
            reads        <= reads + 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of the instruction set
    function automatic bit two_word(input logic [15:0] w);
        return (w[15:12] == 4'd4) || (w[15:12] == 4'd15);
    endfunction

    function automatic logic [15:0] model_next(input logic [15:0] p, input bit cond);
        logic [15:0] w;
        logic [15:0] p1;
        w  = iram[p];
        p1 = p + 16'd1;
        if (w[15:12] == 4'd15 && cond) return iram[p1];
        if (two_word(w)) return p + 16'd2;
        return p1;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_pc"},   32'(pc), 32'h0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'h0);
        chk({tag, "_imm"},  32'(bus.instr_imm), 32'h0);
        chk({tag, "_misc"}, 32'({bus.mem_ctrl, bus.instr_valid, bus.instr_opcode, bus.instr_opa,
                                 bus.instr_opb, halted, fault}), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero(tag);
    endtask

    task automatic wait_valid(input string tag, input int exp_lat, input int cnt0);
        int cnt;
        cnt = cnt0;
        while (!bus.instr_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
    endtask

    task automatic chk_issue(input string tag, input logic [15:0] p);
        logic [15:0] w;
        logic [15:0] p1;
        w  = iram[p];
        p1 = p + 16'd1;
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'h1);
        chk({tag, "_pc"},    32'(pc), 32'(p));
        chk({tag, "_fields"}, 32'({bus.instr_opcode, bus.instr_opa, bus.instr_opb}),
            32'({w[15:12], w[11:7], w[6:2]}));
        chk({tag, "_imm"}, 32'(bus.instr_imm), two_word(w) ? 32'(iram[p1]) : 32'h0);
    endtask

    // Check the held instruction, optionally stall, accept it, and follow to the next one
    task automatic accept(input string tag, input logic [15:0] p, input bit cond, input int hold,
                          output logic [15:0] np, output bit h);
        int unsigned r0;
        h  = 1'b0;
        np = model_next(p, cond);
        chk_issue(tag, p);
        r0 = reads;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk_issue({tag, "_hold"}, p);
        end
        if (hold > 0) chk({tag, "_hold_noread"}, reads, r0);
        bus.jmp_cond    = cond;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        bus.jmp_cond    = 1'b0;
        chk({tag, "_one_accept"}, 32'(bus.instr_valid), 32'h0);
        if (iram[p][15:12] == 4'd1) begin
            h = 1'b1;
            chk({tag, "_halted"}, 32'({halted, fault, bus.mem_ctrl}), 32'b1_0_00);
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (3) tick();
            chk({tag, "_halt_quiet"}, 32'({halted, bus.mem_ctrl, bus.instr_valid}), 32'b1_00_0);
            chk({tag, "_halt_noread"}, reads, r0);
            return;
        end
`ifdef IFU_BOUNDS_CHECK_EN
        if (np > 16'd63) begin
            h = 1'b1;
            chk({tag, "_fault"}, 32'({halted, fault, bus.mem_ctrl}), 32'b1_1_00);
            repeat (3) tick();
            chk({tag, "_fault_noread"}, reads, r0);
            return;
        end
`endif
        chk({tag, "_fetch_ctrl"}, 32'(bus.mem_ctrl), 32'h1);
        chk({tag, "_fetch_addr"}, 32'(bus.mem_addr), 32'(np));
        wait_valid(tag, two_word(iram[np]) ? 5 : 3, 1);
    endtask

    task automatic run_prog(input string tag, input int n, input logic [31:0] cond_bits,
                            input int hold_first);
        logic [15:0] p;
        logic [15:0] np;
        bit          h;
        p = 16'h0;
        h = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_first_addr"}, 32'({bus.mem_ctrl, bus.mem_addr}), 32'h10000);
        wait_valid({tag, "_start"}, two_word(iram[0]) ? 5 : 3, 1);
        for (int i = 0; i < n && !h; i++) begin
            accept(tag, p, cond_bits[i], (i == 0) ? hold_first : 0, np, h);
            p = np;
        end
    endtask

    task automatic clear_iram();
        for (int a = 0; a < 65536; a++) iram[a] = 16'h0;
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        bus.instr_ready = 1'b0;
        bus.jmp_cond    = 1'b0;
        clear_iram();
        do_reset("reset");

        // Straight-line program with 10 cycles of backpressure on the first instruction
        iram[0] = 16'h207C;
        iram[1] = 16'h1000;
        run_prog("straight", 4, 32'h0, 10);

        // Two-word LOAD followed by END at address 2
        do_reset("reset2");
        clear_iram();
        iram[0] = 16'h4004;
        iram[1] = 16'h0005;
        iram[2] = 16'h1000;
        run_prog("load", 4, 32'h0, 0);

        // JMPZ at 51 taken to 39, then not taken to 53
        do_reset("reset3");
        clear_iram();
        iram[0]  = 16'hF000;
        iram[1]  = 16'd51;
        iram[51] = 16'hF000;
        iram[52] = 16'd39;
        iram[39] = 16'h1000;
        iram[53] = 16'h1000;
        run_prog("br_taken", 4, 32'h3, 0);
        do_reset("reset4");
        run_prog("br_not", 4, 32'h1, 0);

        // Reset while the immediate read is in flight
        do_reset("reset5");
        clear_iram();
        iram[0] = 16'h4004;
        iram[1] = 16'h0005;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero("rst_latch_imm");
        repeat (2) tick();
        chk("rst_idle_quiet", 32'({bus.mem_ctrl, bus.instr_valid}), 32'h0);
        iram[0] = 16'h207C;
        iram[1] = 16'h1000;
        run_prog("refetch", 4, 32'h0, 0);

        // Jump to 64: fault under bounds checking, plain read otherwise
        do_reset("reset6");
        clear_iram();
        iram[0]  = 16'hF000;
        iram[1]  = 16'd64;
        iram[64] = 16'h1000;
        run_prog("bound64", 4, 32'h1, 0);

        // PC wrap: jump to 16'hFFFF, next sequential pc is 0
        do_reset("reset7");
        iram[1]     = 16'hFFFF;
        iram[16'hFFFF] = 16'h0000;
        run_prog("wrap", 3, 32'h5, 0);

        // Random programs confined to words 0..63
        for (int k = 0; k < 4; k++) begin
            logic [15:0] w;
            do_reset("reset_rnd");
            clear_iram();
            for (int a = 0; a < 64; a++) begin
                w = 16'($urandom);
                if (w[15:12] == 4'd1) w[15:12] = 4'd0;
                iram[a] = w;
            end
            for (int a = 0; a < 63; a++) begin
                if (iram[a][15:12] == 4'd15) iram[a + 1] = 16'($urandom_range(0, 20));
            end
            run_prog("rnd", 20, $urandom, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
